// File: rtl/tail_light_seq.sv
// Sequential tail-light controller: prescaled animation steps drive a
// left/right fill sequence, a hazard flasher, and a combinational brake overlay.
module tail_light_seq #(
   parameter int LAMPS = 3,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             left,
   input  logic             right,
   input  logic             hazard,
   input  logic             brake,
   output logic [LAMPS-1:0] lamp_l,
   output logic [LAMPS-1:0] lamp_r,
   output logic             busy
);

   // state | meaning
   // IDLE  | no animation; lamps dark or brake-lit, waiting for a request
   // LEFT  | left fill sequence, p lamps lit from the inside out
   // RIGHT | right fill sequence, mirror of LEFT
   // HAZ   | hazard on-phase, every lamp lit for one step

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW = $clog2(LAMPS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [PW-1:0] P_MAX   = PW'(LAMPS);
   localparam logic [PW-1:0] P_ONE   = PW'(1);

   typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   p, p_nxt;
   logic [CW-1:0]   cnt;
   logic            tick;
   logic [LAMPS-1:0] fill;

   // With DIV=1 the count is pinned at 0 and tick holds high every cycle.
   assign tick = (cnt == CNT_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         p     <= P_ONE;
      end else begin
         state <= state_nxt;
         p     <= p_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      p_nxt     = p;
      if (tick) begin
         case (state)
            IDLE: begin
               if (hazard || (left && right)) begin
                  state_nxt = HAZ;
               end else if (left) begin
                  state_nxt = LEFT;
                  p_nxt     = P_ONE;
               end else if (right) begin
                  state_nxt = RIGHT;
                  p_nxt     = P_ONE;
               end
            end
            LEFT, RIGHT: begin
               if (hazard) begin
                  state_nxt = HAZ;
                  p_nxt     = P_ONE;
               end else if (p < P_MAX) begin
                  p_nxt = p + P_ONE;
               end else begin
                  state_nxt = IDLE;
                  p_nxt     = P_ONE;
               end
            end
            HAZ: begin
               state_nxt = IDLE;
               p_nxt     = P_ONE;
            end
            default: begin
               state_nxt = IDLE;
               p_nxt     = P_ONE;
            end
         endcase
      end
   end

   always_comb begin
      fill = '0;
      for (int i = 0; i < LAMPS; i++) fill[i] = (i < int'(p));
   end

   // Brake lights whichever side is not animating; hazard overrides brake.
   always_comb begin
      lamp_l = '0;
      lamp_r = '0;
      case (state)
         IDLE: begin
            if (brake) begin
               lamp_l = '1;
               lamp_r = '1;
            end
         end
         LEFT: begin
            lamp_l = fill;
            if (brake) lamp_r = '1;
         end
         RIGHT: begin
            lamp_r = fill;
            if (brake) lamp_l = '1;
         end
         HAZ: begin
            lamp_l = '1;
            lamp_r = '1;
         end
         default: begin
            lamp_l = '0;
            lamp_r = '0;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_tail_light_seq.sv
// Bench for tail_light_seq: a LAMPS=3/DIV=4 and a LAMPS=8/DIV=1 instance share
// stimulus; a per-cycle model check plus literal spot checks at known steps.
module tb_tail_light_seq;
   logic clk = 1'b0;
   logic reset, left, right, hazard, brake;
   logic [2:0] lamp_l_a, lamp_r_a;
   logic       busy_a;
   logic [7:0] lamp_l_b, lamp_r_b;
   logic       busy_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tail_light_seq #(.LAMPS(3), .DIV(4)) dut_a (
      .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
      .brake(brake), .lamp_l(lamp_l_a), .lamp_r(lamp_r_a), .busy(busy_a));

   tail_light_seq #(.LAMPS(8), .DIV(1)) dut_b (
      .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
      .brake(brake), .lamp_l(lamp_l_b), .lamp_r(lamp_r_b), .busy(busy_b));

   // Model: mode 0 idle, 1 left, 2 right, 3 hazard; step = lamps lit in a turn.
   int lv[2]     = '{3, 8};
   int dv[2]     = '{4, 1};
   int m_mode[2] = '{0, 0};
   int m_step[2] = '{1, 1};
   int m_cyc[2]  = '{0, 0};

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] full_mask(int k);
      return 8'((1 << lv[k]) - 1);
   endfunction

   function automatic logic [7:0] exp_side(int k, bit is_left);
      int anim;
      anim = is_left ? 1 : 2;
      if (m_mode[k] == 3) return full_mask(k);
      if (m_mode[k] == anim) return 8'((1 << m_step[k]) - 1);
      return brake ? full_mask(k) : 8'h00;
   endfunction

   task automatic model_tick(int k);
      bit tk;
      tk = (m_cyc[k] % dv[k]) == (dv[k] - 1);
      m_cyc[k]++;
      if (!tk) return;
      case (m_mode[k])
         0: begin
            if (hazard || (left && right)) m_mode[k] = 3;
            else if (left)  begin m_mode[k] = 1; m_step[k] = 1; end
            else if (right) begin m_mode[k] = 2; m_step[k] = 1; end
         end
         1, 2: begin
            if (hazard)                m_mode[k] = 3;
            else if (m_step[k] < lv[k]) m_step[k]++;
            else                       m_mode[k] = 0;
         end
         default: m_mode[k] = 0;
      endcase
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_step[k] = 1;
            m_cyc[k]  = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) model_tick(k);
      end
   end

   always @(negedge clk) begin
      check("a lamp_l", {5'b0, lamp_l_a}, exp_side(0, 1'b1));
      check("a lamp_r", {5'b0, lamp_r_a}, exp_side(0, 1'b0));
      check("a busy",   {7'b0, busy_a},   {7'b0, m_mode[0] != 0});
      check("b lamp_l", lamp_l_b,         exp_side(1, 1'b1));
      check("b lamp_r", lamp_r_b,         exp_side(1, 1'b0));
      check("b busy",   {7'b0, busy_b},   {7'b0, m_mode[1] != 0});
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
      step(3);
      check("rst a lamp_l", {5'b0, lamp_l_a}, 8'h00);
      check("rst a busy",   {7'b0, busy_a},   8'h00);
      check("rst b lamp_l", lamp_l_b,         8'h00);
      brake = 1'b1; #1;
      check("rst brake a lamp_r", {5'b0, lamp_r_a}, 8'h07);
      check("rst brake b lamp_l", lamp_l_b,         8'hFF);
      brake = 1'b0;

      // left held from release; edges counted from release below
      @(negedge clk); reset = 1'b0; left = 1'b1;
      step(1);  check("b fill1",  lamp_l_b, 8'h01);
      step(2);  check("b fill3",  lamp_l_b, 8'h07);
      step(1);  check("a 001",    {5'b0, lamp_l_a}, 8'h01);
                check("a r dark", {5'b0, lamp_r_a}, 8'h00);
                check("a busy1",  {7'b0, busy_a},   8'h01);
      step(4);  check("a 011",    {5'b0, lamp_l_a}, 8'h03);
                check("b full",   lamp_l_b, 8'hFF);
      step(1);  check("b off",    lamp_l_b, 8'h00);
      step(3);  check("a 111",    {5'b0, lamp_l_a}, 8'h07);
      step(4);  check("a off",    {5'b0, lamp_l_a}, 8'h00);
                check("a off busy", {7'b0, busy_a}, 8'h00);
      step(4);  check("a 001 again", {5'b0, lamp_l_a}, 8'h01);

      // brake overlay, including a mid-step toggle (t=20)
      brake = 1'b1; #1;
      check("brake r lit", {5'b0, lamp_r_a}, 8'h07);
      check("brake l anim", {5'b0, lamp_l_a}, 8'h01);
      brake = 1'b0; #1;
      check("brake r drop", {5'b0, lamp_r_a}, 8'h00);
      brake = 1'b1;
      step(12); check("brake idle l", {5'b0, lamp_l_a}, 8'h07);
                check("brake idle r", {5'b0, lamp_r_a}, 8'h07);
                check("brake idle busy", {7'b0, busy_a}, 8'h00);
      left = 1'b0; brake = 1'b0;

      // right pulsed only across the tick edge at t=40; left pulse ignored
      step(7);  right = 1'b1;
      step(1);  right = 1'b0;
                check("r pulse 001", {5'b0, lamp_r_a}, 8'h01);
                check("r pulse l",   {5'b0, lamp_l_a}, 8'h00);
      step(3);  left = 1'b1;
      step(1);  left = 1'b0;
                check("r 011", {5'b0, lamp_r_a}, 8'h03);
                check("r l ignored", {5'b0, lamp_l_a}, 8'h00);
      step(4);  check("r 111", {5'b0, lamp_r_a}, 8'h07);
      step(4);  check("r off", {5'b0, lamp_r_a}, 8'h00);
                check("r off busy", {7'b0, busy_a}, 8'h00);

      // left+right held -> hazard flash
      left = 1'b1; right = 1'b1;
      step(4);  check("haz on l", {5'b0, lamp_l_a}, 8'h07);
                check("haz on r", {5'b0, lamp_r_a}, 8'h07);
                check("haz busy", {7'b0, busy_a},   8'h01);
      step(4);  check("haz off l", {5'b0, lamp_l_a}, 8'h00);
                check("haz off r", {5'b0, lamp_r_a}, 8'h00);
      step(4);  check("haz on2 l", {5'b0, lamp_l_a}, 8'h07);
      left = 1'b0; right = 1'b0;
      step(4);  check("haz end", {5'b0, lamp_l_a}, 8'h00);

      // hazard aborts a left sequence at 011
      left = 1'b1;
      step(8);  check("abort at 011", {5'b0, lamp_l_a}, 8'h03);
      left = 1'b0; hazard = 1'b1;
      step(4);  check("abort haz l", {5'b0, lamp_l_a}, 8'h07);
                check("abort haz r", {5'b0, lamp_r_a}, 8'h07);
      hazard = 1'b0;
      step(4);  check("abort idle l", {5'b0, lamp_l_a}, 8'h00);
                check("abort idle busy", {7'b0, busy_a}, 8'h00);

      // asynchronous reset mid-sequence, then restart timing
      left = 1'b1;
      step(8);  check("pre-reset 011", {5'b0, lamp_l_a}, 8'h03);
      #3 reset = 1'b1;
      #1;
      check("async rst lamp_l", {5'b0, lamp_l_a}, 8'h00);
      check("async rst busy",   {7'b0, busy_a},   8'h00);
      check("async rst b busy", {7'b0, busy_b},   8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      step(3);  check("post-rst still off", {5'b0, lamp_l_a}, 8'h00);
      step(1);  check("post-rst first step", {5'b0, lamp_l_a}, 8'h01);
      left = 1'b0;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tail_light_seq.md
TAIL_LIGHT_SEQ -- requirements
Module: tail_light_seq

Interface
REQ-001 Parameter LAMPS, default 3: lamps per side; legal range 2..8.
REQ-002 Parameter DIV, default 4: clock cycles per animation step; legal range 1..65535.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 left  input  1  left-turn request, level-sensitive.
REQ-006 right  input  1  right-turn request, level-sensitive.
REQ-007 hazard  input  1  hazard-flasher request, level-sensitive.
REQ-008 brake  input  1  brake pedal, level-sensitive.
REQ-009 lamp_l  output  LAMPS  left lamps; bit 0 innermost, bit LAMPS-1 outermost; 1 = lit.
REQ-010 lamp_r  output  LAMPS  right lamps; same bit ordering as lamp_l.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Prescaler: free-running counter 0..DIV-1, width ceil(log2(DIV)) (min 1 bit); tick asserted for the one cycle in which the count equals DIV-1, then the count wraps to 0.
REQ-013 DIV=1: tick asserted every cycle.
REQ-014 FSM states: IDLE, LEFT, RIGHT, HAZ; step index p, range 1..LAMPS, used in LEFT/RIGHT only.
REQ-015 FSM state and p change only on a cycle in which tick is asserted; all inputs are sampled on that same edge.
REQ-016 IDLE on tick, priority order: hazard=1 or (left=1 and right=1) -> HAZ; else left=1 -> LEFT with p=1; else right=1 -> RIGHT with p=1; else remain IDLE.
REQ-017 LEFT/RIGHT on tick with hazard=0: p<LAMPS -> p+1; p=LAMPS -> IDLE.
REQ-018 left/right changes during LEFT/RIGHT are ignored; the sequence always runs to completion.
REQ-019 Any non-HAZ state on tick with hazard=1 -> HAZ (abort in progress).
REQ-020 HAZ on tick -> IDLE unconditionally; a held hazard input therefore alternates HAZ/IDLE each step (50% flash).
REQ-021 Turn pattern: in LEFT, lamp_l bits [p-1:0] are lit and the rest are dark; RIGHT mirrors this on lamp_r.
REQ-022 HAZ: all bits of lamp_l and lamp_r lit, regardless of brake.
REQ-023 Brake overlay, brake=1: in IDLE both sides fully lit; in LEFT lamp_r fully lit; in RIGHT lamp_l fully lit; the animated side is unaffected.
REQ-024 Brake overlay, brake=0: the non-animated side and IDLE lamps are dark.
REQ-025 Outputs are combinational from the registered state, p and the brake input; brake has zero-cycle latency, all other inputs at least one tick.
REQ-026 One turn cycle lasts (LAMPS+1) steps: LAMPS fill steps plus one IDLE off step before the next sequence can begin.

Reset
REQ-027 While reset=1: state=IDLE, p=1, prescaler count=0, busy=0, lamps dark except for the brake overlay (REQ-023).
REQ-028 Reset asserted mid-sequence or mid-hazard takes effect immediately, without waiting for clk.
REQ-029 First tick after reset release occurs DIV cycles after the first clk edge with reset=0.

Verification (LAMPS=3, DIV=4)
REQ-030 left held from reset release -> lamp_l steps 001,011,111,000,001..., each value lasting 4 cycles; lamp_r=000; busy=0 only during the 000 step.
REQ-031 right pulsed high for the single tick-edge cycle only -> full 001,011,111 on lamp_r, then IDLE; left pulsed mid-sequence has no effect.
REQ-032 left and right both held on an IDLE tick -> HAZ: lamp_l=lamp_r=111 and 000 alternating every 4 cycles.
REQ-033 left held, brake=1 -> lamp_r=111 throughout LEFT; lamp_l animates normally; in IDLE both sides are 111; brake toggled mid-step -> lamp_r follows in the same cycle.
REQ-034 hazard asserted while lamp_l=011 -> next tick both sides 111 (HAZ), then IDLE 000 (brake=0).
REQ-035 reset asserted while lamp_l=011, between clk edges -> outputs 000 and busy=0 immediately; after release, the first step change occurs 4 cycles later; also repeat REQ-030 with LAMPS=8, DIV=1 -> one-lamp-per-cycle fill to 8'hFF.
